// File: rtl/ram512_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram512_ctrl_if
// Client-side request/response bus of the 512 x 16 RAM front-end.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The client holds req_we/req_addr/req_wdata stable
// while req_valid is high and not yet accepted. There is no backpressure on
// the response side: rsp_valid is a single-cycle strobe and rsp_data holds
// its value until the next response.
//
// Signals:
//   req_valid  client -> ctrl  request present
//   req_ready  ctrl -> client  request can be taken this cycle
//   req_we     client -> ctrl  1 = write, 0 = read
//   req_addr   client -> ctrl  word address
//   req_wdata  client -> ctrl  write data
//   rsp_valid  ctrl -> client  one-cycle read-data strobe
//   rsp_data   ctrl -> client  read data
// ----------------------------------------------------------------------------
interface ram512_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/ram512_ctrl.sv
// ----------------------------------------------------------------------------
// ram512_ctrl
// Request/response front-end for a 512 x 16 RAM with a registered read port.
// Accepts single-word reads/writes from one client, waits out the RAM read
// latency and returns read data with a one-cycle strobe. A fill engine writes
// one value to every address (memory clear at boot).
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   bus           client request/response bus (slave side)
//   fill_start    start fill, only looked at in IDLE
//   fill_value    fill word, captured together with fill_start
//   fill_busy     fill in progress
//   fill_done     one-cycle pulse after the last fill write
//   ram_in        RAM write data        (registered)
//   ram_address   RAM address           (registered)
//   ram_load      RAM write enable      (registered)
//   ram_out       RAM read data, valid READ_LATENCY edges after ram_address
//   dbg_state     current FSM state, for observation only
//
// DEPTH must equal 2**ADDR_W; READ_LATENCY is legal from 1 to 7.
// ----------------------------------------------------------------------------
module ram512_ctrl #(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 16,
   parameter int DEPTH        = 512,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   ram512_ctrl_if.slave      bus,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   output logic              fill_done,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ_WAIT = 2'd2,
      FILL      = 2'd3
   } state_t;

   localparam int            CNT_W    = 3;
   // The fill counter is one bit wider than the address so that reaching
   // DEPTH (one past the last address) marks the end without wrapping.
   localparam logic [ADDR_W:0] FILL_END = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W:0]     fill_addr_q, fill_addr_d;
   logic [DATA_W-1:0]   fill_word_q, fill_word_d;
   logic [DATA_W-1:0]   ram_in_q, ram_in_d;
   logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
   logic                ram_load_q, ram_load_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                fill_busy_q, fill_busy_d;
   logic                fill_done_q, fill_done_d;

   // A pending fill_start blocks request acceptance so fill wins the cycle.
   assign bus.req_ready = (state_q == IDLE) & ~fill_start;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;

   assign fill_busy   = fill_busy_q;
   assign fill_done   = fill_done_q;
   assign ram_in      = ram_in_q;
   assign ram_address = ram_address_q;
   assign ram_load    = ram_load_q;
   assign dbg_state   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         fill_addr_q   <= '0;
         fill_word_q   <= '0;
         ram_in_q      <= '0;
         ram_address_q <= '0;
         ram_load_q    <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         fill_busy_q   <= 1'b0;
         fill_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         fill_addr_q   <= fill_addr_d;
         fill_word_q   <= fill_word_d;
         ram_in_q      <= ram_in_d;
         ram_address_q <= ram_address_d;
         ram_load_q    <= ram_load_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         fill_busy_q   <= fill_busy_d;
         fill_done_q   <= fill_done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      fill_addr_d   = fill_addr_q;
      fill_word_d   = fill_word_q;
      ram_in_d      = ram_in_q;
      ram_address_d = ram_address_q;
      ram_load_d    = 1'b0;
      rsp_valid_d   = 1'b0;
      rsp_data_d    = rsp_data_q;
      fill_busy_d   = fill_busy_q;
      fill_done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (fill_start) begin
               // Address 0 is driven straight from the start edge, so the
               // counter holds the next address to write and fill_busy and
               // ram_load are both high for exactly DEPTH cycles.
               fill_word_d   = fill_value;
               ram_address_d = '0;
               ram_in_d      = fill_value;
               ram_load_d    = 1'b1;
               fill_addr_d   = (ADDR_W+1)'(1);
               fill_busy_d   = 1'b1;
               state_d       = FILL;
            end else if (bus.req_valid) begin
               ram_address_d = bus.req_addr;
               if (bus.req_we) begin
                  ram_in_d   = bus.req_wdata;
                  ram_load_d = 1'b1;
                  state_d    = WRITE;
               end else begin
                  cnt_d   = CNT_W'(READ_LATENCY);
                  state_d = READ_WAIT;
               end
            end
         end

         // RAM commits the write on this edge; ram_load drops by default.
         WRITE: begin
            state_d = IDLE;
         end

         // ram_address is left untouched, so it stays stable for the read.
         READ_WAIT: begin
            if (cnt_q == '0) begin
               rsp_data_d  = ram_out;
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         FILL: begin
            if (fill_addr_q == FILL_END) begin
               fill_busy_d = 1'b0;
               fill_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               ram_address_d = fill_addr_q[ADDR_W-1:0];
               ram_in_d      = fill_word_q;
               ram_load_d    = 1'b1;
               fill_addr_d   = fill_addr_q + (ADDR_W+1)'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/ram512_ctrl.md
Name: ram512_ctrl

Overview:
Request/response front-end that sits directly upstream of the 512 x 16 RAM and drives its in/address/load pins. Clients issue single-word read/write requests over a valid/ready handshake. The block sequences the RAM's registered read latency and returns read data with a one-cycle response strobe. A built-in fill engine writes one value to every address, used for memory clear at boot.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 16, RAM word width
DEPTH, 512, number of words (must equal 2**ADDR_W)
READ_LATENCY, 1, clock edges from ram_address applied to ram_out valid (legal 1..7)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  client request present
req_ready  output  1  block accepts request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle read-data strobe
rsp_data  output  DATA_W  read data, held until next response
fill_start  input  1  start fill engine (sampled in IDLE only)
fill_value  input  DATA_W  fill word, captured on fill_start
fill_busy  output  1  fill in progress
fill_done  output  1  one-cycle pulse after last fill write
ram_in  output  DATA_W  to RAM in
ram_address  output  ADDR_W  to RAM address
ram_load  output  1  to RAM load
ram_out  input  DATA_W  from RAM out

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, req_ready reflects IDLE, rsp_valid 0, rsp_data 0, fill_busy 0, fill_done 0, ram_in 0, ram_address 0, ram_load 0, latency counter 0.
- All RAM-side outputs are registered. ram_address/ram_in hold their last value when idle.
- req_ready = (state == IDLE) & ~fill_start, combinational. A transfer occurs on a rising edge with req_valid & req_ready.
- States: IDLE, WRITE, READ_WAIT, FILL.
- IDLE, write accepted at edge E0:
  - After E0: ram_address=req_addr, ram_in=req_wdata, ram_load=1, state WRITE.
  - The RAM commits at E1. After E1: ram_load=0, state IDLE.
  - One write per 2 cycles. No response strobe for writes.
- IDLE, read accepted at E0:
  - After E0: ram_address=req_addr, ram_load=0, counter=READ_LATENCY, state READ_WAIT.
  - Counter decrements each edge. At the edge where it is 0, rsp_data is captured from ram_out and state returns to IDLE. This is edge E0+READ_LATENCY+1.
  - rsp_valid is high for exactly the following cycle.
  - ram_address is held stable for the whole read.
- IDLE with fill_start=1: fill wins over a concurrent req_valid; no request is accepted that cycle.
  - At that edge: capture fill_value, counter address=0, fill_busy=1, state FILL.
  - FILL: each cycle drives ram_address=fill addr, ram_in=fill word, ram_load=1. Address increments by 1 per edge.
  - After the write to DEPTH-1 is driven, the next edge sets ram_load=0, fill_busy=0, fill_done=1 (one cycle), state IDLE.
  - Exactly DEPTH consecutive ram_load cycles, addresses 0..DEPTH-1 ascending, no wrap.
- fill_start outside IDLE is ignored.
- Changes to req_* or fill_value after acceptance have no effect.
- Reset mid-operation (any state): immediate return to reset values and ram_load drops asynchronously. RAM contents are not cleared; a partial fill remains. A pending read produces no rsp_valid.
- Write then read to the same address returns the new value; the write commits before the read is accepted.
- Address arithmetic is unsigned ADDR_W bits; the fill counter is ADDR_W+1 bits to detect the end.

Test Plan:
1. Reset: rst_n low mid-cycle -> all outputs at reset values without a clock edge; req_ready=1 after release.
2. Write 0xBEEF @ 0x0A5, then read 0x0A5 -> ram_load high exactly 1 cycle with address 0x0A5. Read rsp_valid 1 cycle, READ_LATENCY+1 edges after accept, rsp_data=0xBEEF.
3. Boundary addresses: write 0x1234 @ 0x000 and 0x5678 @ 0x1FF, read both -> 0x1234, 0x5678; neighbours 0x001/0x1FE are unaffected.
4. Fill with 0x00FF -> fill_busy for 512 cycles, ram_load high 512 consecutive cycles at addresses 0..511, single fill_done pulse. Random reads then return 0x00FF.
5. Same-cycle fill_start and req_valid -> req_ready=0, fill runs, and the request is accepted afterwards. req_valid during READ_WAIT -> stalled (req_ready=0).
6. Assert rst_n low at fill address 200 -> fill_busy=0, no fill_done. Read 199 returns the fill value; read 201 returns its prior contents.
